// File: rtl/btb_sat_predictor_if.sv
// Fetch/execute-side bundle for the branch target buffer: IF lookup, EX resolution,
// flush control and performance status.
interface btb_sat_predictor_if #(
   parameter int PC_W  = 16,
   parameter int CNT_W = 16
);
   logic [PC_W-1:0]  IF_pc_plus_one;
   logic             BTB_taken;
   logic [PC_W-1:0]  BTB_target;
   logic             EX_is_branch;
   logic [PC_W-1:0]  EX_pc_plus_one;
   logic             EX_branch_taken;
   logic [PC_W-1:0]  EX_branch_target;
   logic             EX_pred_taken;
   logic             flush_req;
   logic             busy;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output IF_pc_plus_one, EX_is_branch, EX_pc_plus_one, EX_branch_taken,
             EX_branch_target, EX_pred_taken, flush_req,
      input  BTB_taken, BTB_target, busy, mispredict_cnt
   );

   modport slave (
      input  IF_pc_plus_one, EX_is_branch, EX_pc_plus_one, EX_branch_taken,
             EX_branch_target, EX_pred_taken, flush_req,
      output BTB_taken, BTB_target, busy, mispredict_cnt
   );
endinterface

// File: rtl/btb_sat_predictor.sv
// Direct-mapped tagged BTB with saturating direction counters, a one-entry-per-cycle
// flush sweep, and a saturating mispredict counter.
module btb_sat_predictor #(
   parameter int PC_W  = 16,
   parameter int IDX_W = 5,
   parameter int CTR_W = 2,
   parameter int CNT_W = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   btb_sat_predictor_if.slave  bus
);
   localparam int DEPTH = 2**IDX_W;
   localparam int TAG_W = PC_W - IDX_W;
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W-1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t                      state, state_nxt;
   logic [IDX_W-1:0]            ptr;
   logic [DEPTH-1:0]            valid;
   logic [DEPTH-1:0][CTR_W-1:0] ctr;
   logic [TAG_W-1:0]            tag_mem [DEPTH];
   logic [PC_W-1:0]             tgt_mem [DEPTH];

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit, busy, taken, upd;
   logic [CTR_W-1:0] ex_ctr, ctr_inc, ctr_dec;

   assign if_idx = bus.IF_pc_plus_one[IDX_W-1:0];
   assign if_tag = bus.IF_pc_plus_one[PC_W-1:IDX_W];
   assign ex_idx = bus.EX_pc_plus_one[IDX_W-1:0];
   assign ex_tag = bus.EX_pc_plus_one[PC_W-1:IDX_W];

   assign busy   = (state == FLUSH);
   assign upd    = bus.EX_is_branch && (state == IDLE);

   // Lookup reads pre-update contents; a same-cycle EX write shows up next cycle.
   assign if_hit = valid[if_idx] && (tag_mem[if_idx] == if_tag);
   assign taken  = if_hit && ctr[if_idx][CTR_W-1] && !busy;

   assign bus.busy       = busy;
   assign bus.BTB_taken  = taken;
   assign bus.BTB_target = taken ? tgt_mem[if_idx] : '0;

   assign ex_hit  = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);
   assign ex_ctr  = ctr[ex_idx];
   assign ctr_inc = (ex_ctr == '1) ? ex_ctr : ex_ctr + CTR_W'(1);
   assign ctr_dec = (ex_ctr == '0) ? ex_ctr : ex_ctr - CTR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.flush_req) state_nxt = FLUSH;
         FLUSH:   if (ptr == LAST_IDX) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pointer parks at 0 while idle, so every sweep starts from entry 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              ptr <= '0;
      else if (state == IDLE)  ptr <= '0;
      else if (ptr != LAST_IDX) ptr <= ptr + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         ctr   <= '0;
      end else if (state == FLUSH) begin
         valid[ptr] <= 1'b0;
         ctr[ptr]   <= '0;
      end else if (bus.EX_is_branch) begin
         if (ex_hit) begin
            ctr[ex_idx] <= bus.EX_branch_taken ? ctr_inc : ctr_dec;
         end else if (bus.EX_branch_taken) begin
            valid[ex_idx] <= 1'b1;
            ctr[ex_idx]   <= CTR_WEAK;
         end
      end
   end

   // Tag and target carry no reset; valid gates every use of them.
   always_ff @(posedge clk) begin
      if (upd && bus.EX_branch_taken) begin
         tag_mem[ex_idx] <= ex_tag;
         tgt_mem[ex_idx] <= bus.EX_branch_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bus.mispredict_cnt <= '0;
      else if (bus.EX_is_branch && (bus.EX_pred_taken != bus.EX_branch_taken) &&
               (bus.mispredict_cnt != '1))
         bus.mispredict_cnt <= bus.mispredict_cnt + 1'b1;
   end
endmodule

// File: tb/tb_btb_sat_predictor.sv
// Directed bench for btb_sat_predictor: counters, aliasing, bypass-free lookup,
// flush sweep, reset mid-flush, and counter saturation on a narrow instance.
module tb_btb_sat_predictor;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   cycles;

   always #5 clk = ~clk;

   btb_sat_predictor_if #(.PC_W(16), .CNT_W(16)) b ();
   btb_sat_predictor_if #(.PC_W(16), .CNT_W(2))  bs ();

   btb_sat_predictor #(.PC_W(16), .IDX_W(5), .CTR_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b)
   );
   btb_sat_predictor #(.PC_W(16), .IDX_W(5), .CTR_W(2), .CNT_W(2)) dut_small (
      .clk(clk), .rst_n(rst_n), .bus(bs)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input logic [15:0] pc);
      b.IF_pc_plus_one = pc;
      #1;
   endtask

   task automatic ex_upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                         input logic pred);
      b.EX_pc_plus_one   = pc;
      b.EX_branch_taken  = tk;
      b.EX_branch_target = tgt;
      b.EX_pred_taken    = pred;
      b.EX_is_branch     = 1'b1;
      tick();
      b.EX_is_branch     = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      b.IF_pc_plus_one = '0;   b.EX_is_branch = 1'b0;   b.EX_pc_plus_one = '0;
      b.EX_branch_taken = 1'b0; b.EX_branch_target = '0; b.EX_pred_taken = 1'b0;
      b.flush_req = 1'b0;
      bs.IF_pc_plus_one = '0;  bs.EX_is_branch = 1'b0;  bs.EX_pc_plus_one = '0;
      bs.EX_branch_taken = 1'b0; bs.EX_branch_target = '0; bs.EX_pred_taken = 1'b0;
      bs.flush_req = 1'b0;
      tick(); tick();
      look(16'h0123);
      chk("rst_taken", b.BTB_taken, 0);
      chk("rst_target", b.BTB_target, 0);
      chk("rst_busy", b.busy, 0);
      chk("rst_cnt", b.mispredict_cnt, 0);
      rst_n = 1'b1;
      tick();

      // Allocate weakly taken, then walk the counter down and up.
      ex_upd(16'h0123, 1, 16'h0400, 1);
      look(16'h0123);
      chk("alloc_taken", b.BTB_taken, 1);
      chk("alloc_target", b.BTB_target, 16'h0400);
      ex_upd(16'h0123, 0, 16'h0000, 0);
      look(16'h0123);
      chk("ctr01_taken", b.BTB_taken, 0);
      chk("ctr01_target", b.BTB_target, 0);
      ex_upd(16'h0123, 0, 16'h0000, 0);
      ex_upd(16'h0123, 0, 16'h0000, 0);
      ex_upd(16'h0123, 1, 16'h0500, 1);
      look(16'h0123);
      chk("floor_then_inc", b.BTB_taken, 0);
      for (int i = 0; i < 4; i++) ex_upd(16'h0123, 1, 16'h0500, 1);
      look(16'h0123);
      chk("sat_taken", b.BTB_taken, 1);
      chk("sat_target", b.BTB_target, 16'h0500);
      ex_upd(16'h0123, 0, 16'h0000, 0);
      look(16'h0123);
      chk("ceil_dec1", b.BTB_taken, 1);
      ex_upd(16'h0123, 0, 16'h0000, 0);
      look(16'h0123);
      chk("ceil_dec2", b.BTB_taken, 0);
      ex_upd(16'h0123, 1, 16'h0500, 1);

      // Aliasing on index 3.
      look(16'h0163);
      chk("alias_miss", b.BTB_taken, 0);
      ex_upd(16'h0163, 1, 16'h0600, 1);
      look(16'h0163);
      chk("evict_taken", b.BTB_taken, 1);
      chk("evict_target", b.BTB_target, 16'h0600);
      look(16'h0123);
      chk("evicted_miss", b.BTB_taken, 0);
      ex_upd(16'h0123, 0, 16'h0000, 0);
      look(16'h0163);
      chk("miss_nt_nochg", b.BTB_taken, 1);
      chk("miss_nt_tgt", b.BTB_target, 16'h0600);

      // Same-cycle update and lookup: no bypass.
      b.IF_pc_plus_one = 16'h0045;
      b.EX_pc_plus_one = 16'h0045; b.EX_branch_taken = 1'b1;
      b.EX_branch_target = 16'h0777; b.EX_pred_taken = 1'b1; b.EX_is_branch = 1'b1;
      #1;
      chk("same_cyc_old", b.BTB_taken, 0);
      tick();
      b.EX_is_branch = 1'b0;
      #1;
      chk("same_cyc_new", b.BTB_taken, 1);
      chk("same_cyc_tgt", b.BTB_target, 16'h0777);

      // Mispredict counting.
      ex_upd(16'h0045, 1, 16'h0777, 0);
      ex_upd(16'h0045, 0, 16'h0000, 1);
      b.EX_pred_taken = 1'b1; b.EX_branch_taken = 1'b0;
      tick();
      chk("mp_cnt2", b.mispredict_cnt, 2);

      // Fill, then sweep.
      for (int i = 0; i < 32; i++) ex_upd(16'h0100 + 16'(i), 1, 16'h1000 + 16'(i), 1);
      look(16'h0100);
      chk("fill_first", b.BTB_target, 16'h1000);
      look(16'h011F);
      chk("fill_last", b.BTB_target, 16'h101F);
      b.flush_req = 1'b1;
      b.EX_pc_plus_one = 16'h0208; b.EX_branch_taken = 1'b1;
      b.EX_branch_target = 16'h0888; b.EX_pred_taken = 1'b1; b.EX_is_branch = 1'b1;
      tick();
      b.flush_req = 1'b0; b.EX_is_branch = 1'b0;
      look(16'h011F);
      chk("flush_busy", b.busy, 1);
      chk("flush_forced0", b.BTB_taken, 0);
      cycles = 0;
      while (b.busy && cycles < 100) begin
         cycles++;
         b.flush_req = (cycles == 3);
         if (cycles == 30) begin
            b.EX_pc_plus_one = 16'h0203; b.EX_branch_taken = 1'b1;
            b.EX_branch_target = 16'h0333; b.EX_pred_taken = 1'b0; b.EX_is_branch = 1'b1;
         end else begin
            b.EX_is_branch = 1'b0;
         end
         tick();
      end
      b.flush_req = 1'b0; b.EX_is_branch = 1'b0;
      chk("flush_len", cycles, 32);
      look(16'h0100);
      chk("post_flush_0100", b.BTB_taken, 0);
      look(16'h011F);
      chk("post_flush_011f", b.BTB_taken, 0);
      look(16'h0203);
      chk("flush_upd_dropped", b.BTB_taken, 0);
      look(16'h0208);
      chk("flush_swept_upd", b.BTB_taken, 0);
      chk("mp_cnt_flush", b.mispredict_cnt, 3);
      tick();
      chk("no_restart", b.busy, 0);

      // Reset in the middle of a sweep.
      ex_upd(16'h031E, 1, 16'h0999, 1);
      b.flush_req = 1'b1;
      tick();
      b.flush_req = 1'b0;
      repeat (5) tick();
      chk("mid_busy", b.busy, 1);
      #2;
      rst_n = 1'b0;
      look(16'h031E);
      chk("rst_mid_busy", b.busy, 0);
      chk("rst_mid_taken", b.BTB_taken, 0);
      chk("rst_mid_cnt", b.mispredict_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();
      look(16'h031E);
      chk("rst_mid_inval", b.BTB_taken, 0);
      chk("rst_mid_idle", b.busy, 0);
      ex_upd(16'h031E, 1, 16'h0999, 1);
      look(16'h031E);
      chk("rst_mid_realloc", b.BTB_target, 16'h0999);

      // Narrow counter saturates at 3.
      bs.EX_is_branch = 1'b1; bs.EX_pred_taken = 1'b1; bs.EX_branch_taken = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("cnt2_sat", bs.mispredict_cnt, (k < 3) ? k : 3);
      end
      bs.EX_is_branch = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/btb_sat_predictor.md
Name: btb_sat_predictor

Overview:
- Direct-mapped, tagged branch target buffer with per-entry saturating direction counters. It replaces the single-bit, untagged predictor in the fetch stage.
- Lookup is combinational from the IF-stage PC. Update is synchronous from the EX-stage branch resolution.
- Adds a multi-cycle flush sweep and a saturating mispredict counter for performance monitoring.

Parameters:
- PC_W, 16, width of the PC values presented at IF and EX.
- IDX_W, 5, index bits taken from PC[IDX_W-1:0]; depth = 2**IDX_W entries.
- CTR_W, 2, saturating counter width; must be >= 1.
- CNT_W, 16, width of the mispredict performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_pc_plus_one  in  PC_W  fetch-stage lookup PC.
- BTB_taken  out  1  prediction: taken (combinational).
- BTB_target  out  PC_W  predicted target; valid only when BTB_taken=1, else 0.
- EX_is_branch  in  1  EX holds a resolved branch this cycle.
- EX_pc_plus_one  in  PC_W  PC of the resolving branch.
- EX_branch_taken  in  1  resolved direction.
- EX_branch_target  in  PC_W  resolved target.
- EX_pred_taken  in  1  prediction that was made for this branch at IF.
- flush_req  in  1  single-cycle request to invalidate all entries.
- busy  out  1  flush sweep in progress.
- mispredict_cnt  out  CNT_W  saturating count of mispredicted branches.

Behaviour:
- Entry fields: valid, tag = PC[PC_W-1:IDX_W], ctr[CTR_W-1:0], target[PC_W-1:0].
- Reset (async): all valid=0, all ctr=0, FSM=IDLE, busy=0, mispredict_cnt=0. BTB_taken=0 and BTB_target=0 immediately. Tag and target storage need not be reset.
- Lookup:
  - hit = valid[idx] && tag match.
  - BTB_taken = hit && ctr MSB && !busy.
  - BTB_target = BTB_taken ? target : 0.
  - Zero-cycle latency.
- Update applies at posedge when EX_is_branch=1 and FSM=IDLE:
  - Hit, taken: ctr saturating increment (stops at all-ones); target <= EX_branch_target.
  - Hit, not taken: ctr saturating decrement (stops at 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag written, target written, ctr = weakly taken (MSB=1, rest 0; 2'b10 at default). This evicts any previous occupant.
  - Miss, not taken: no change; no allocation.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. There is no bypass; the new value is visible next cycle.
- Mispredict counter:
  - Increments when EX_is_branch && (EX_pred_taken != EX_branch_taken).
  - Counts in both IDLE and FLUSH.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- FSM states: IDLE and FLUSH.
  - IDLE -> FLUSH on flush_req=1. The sweep pointer is set to 0 and busy=1 from the next cycle.
  - FLUSH: each cycle, clear valid[ptr] and ctr[ptr], then ptr+1.
  - After clearing entry 2**IDX_W-1, go to IDLE with busy=0 the following cycle. Total busy duration is exactly 2**IDX_W cycles.
  - In FLUSH, EX updates are dropped (the counter still counts) and BTB_taken is forced to 0.
  - flush_req while busy is ignored; no restart and no extension.
  - A flush_req in the same cycle as an EX update in IDLE applies the update first; the sweep then clears it.
- Reset during FLUSH: immediate return to IDLE with everything invalid.
- Index wrap: the sweep pointer is IDX_W bits wide and terminates on the last index, never wrapping.

Test Plan:
- Reset, then lookup any PC -> BTB_taken=0, BTB_target=0, busy=0, mispredict_cnt=0.
- EX update PC=0x0123, taken, target=0x0400 -> next cycle IF PC=0x0123 gives BTB_taken=1, BTB_target=0x0400, ctr=2'b10. Two not-taken updates -> ctr 01, then 00; BTB_taken=0. Five taken updates -> ctr saturates at 11.
- Alias: after allocating PC 0x0123, lookup 0x0163 (same index, different tag) -> BTB_taken=0. A taken update at 0x0163 evicts, and 0x0123 then misses.
- Same-cycle update and lookup of a new PC -> BTB_taken=0 that cycle, 1 the next cycle.
- Fill 32 entries, pulse flush_req -> busy=1 for exactly 32 cycles. EX updates and a second flush_req during the sweep are ignored. All lookups miss afterward.
- Assert rst_n low mid-flush -> busy=0 immediately, all entries invalid. Set CNT_W=2 and drive 5 mispredicts -> mispredict_cnt=3 and holds.
